// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 window generator and the Sobel convolution stage.
package conv_pkg;

    localparam int unsigned DATA_W     = 12;
    localparam int unsigned WIN_N      = 3;
    localparam int unsigned TAP_NEWEST = 8;
    localparam int unsigned TAP_CENTER = 4;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef pixel_t [WIN_N-1:0][WIN_N-1:0] window_t;

    // Tap (r,c) lands at [(r*WIN_N+c)*DATA_W +: DATA_W]
    function automatic logic [WIN_N*WIN_N*DATA_W-1:0] flatten(input window_t w);
        logic [WIN_N*WIN_N*DATA_W-1:0] f;
        f = '0;
        for (int r = 0; r < int'(WIN_N); r++) begin
            for (int c = 0; c < int'(WIN_N); c++) begin
                f[(r*int'(WIN_N)+c)*int'(DATA_W) +: DATA_W] = w[r][c];
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/gray_line_buf.sv
// Simple dual-port line buffer: synchronous read, read-before-write on address collision, no reset.
module gray_line_buf #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 640,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Non-blocking read and write in one process returns the old word on a same-address hit
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_q <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/gray_window3x3.sv
// Line-buffered 3x3 window generator for the gray pixel stream feeding the Sobel stage.
// Optional `GW_ZERO_BORDER_EN: emit a window per pixel with out-of-frame taps forced to zero.
module gray_window3x3
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = conv_pkg::DATA_W,
    parameter int unsigned IMG_W  = 640,
    parameter int unsigned CNT_W  = 11
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic [DATA_W-1:0]             iDATA,
    input  logic                          iDVAL,
    input  logic [CNT_W-1:0]              iX_Cont,
    input  logic [CNT_W-1:0]              iY_Cont,
    output logic [WIN_N*WIN_N*DATA_W-1:0] oWin,
    output logic                          oDVAL,
    output logic [CNT_W-1:0]              oX_Cont,
    output logic [CNT_W-1:0]              oY_Cont
);

    localparam int unsigned ADDR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef logic [WIN_N-1:0][WIN_N-1:0][DATA_W-1:0] win_t;

    logic [CNT_W-1:0]  col_q, col_d, row_q, row_d;
    logic [CNT_W-1:0]  cur_col_c, cur_row_c;
    logic              resync_c;
    logic              vld_s1_q, vld_s1_d;
    logic [DATA_W-1:0] p_s1_q, p_s1_d;
    logic [CNT_W-1:0]  col_s1_q, col_s1_d, row_s1_q, row_s1_d;
    logic [DATA_W-1:0] t1, t2;
    win_t              win_q, win_d;
    logic              odval_q, odval_d;
    logic [CNT_W-1:0]  ox_q, ox_d, oy_q, oy_d;

    // Upstream (0,0) pins the accepted pixel to the frame origin
    always_comb begin
        resync_c  = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
        cur_col_c = resync_c ? '0 : col_q;
        cur_row_c = resync_c ? '0 : row_q;
    end

    always_comb begin
        col_d    = col_q;
        row_d    = row_q;
        vld_s1_d = iDVAL;
        p_s1_d   = p_s1_q;
        col_s1_d = col_s1_q;
        row_s1_d = row_s1_q;
        if (iDVAL) begin
            p_s1_d   = iDATA;
            col_s1_d = cur_col_c;
            row_s1_d = cur_row_c;
            if (cur_col_c == CNT_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row_c == '1) ? cur_row_c : cur_row_c + CNT_W'(1);
            end else begin
                col_d = cur_col_c + CNT_W'(1);
                row_d = cur_row_c;
            end
        end
    end

    // lb0 holds row-1; lb1 takes lb0's old word one cycle later so it holds row-2
    gray_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(ADDR_W)) u_lb0 (
        .clk     (iCLK),
        .rd_en   (iDVAL),
        .rd_addr (ADDR_W'(cur_col_c)),
        .rd_data (t1),
        .wr_en   (iDVAL),
        .wr_addr (ADDR_W'(cur_col_c)),
        .wr_data (iDATA)
    );

    gray_line_buf #(.DATA_W(DATA_W), .DEPTH(IMG_W), .ADDR_W(ADDR_W)) u_lb1 (
        .clk     (iCLK),
        .rd_en   (iDVAL),
        .rd_addr (ADDR_W'(cur_col_c)),
        .rd_data (t2),
        .wr_en   (vld_s1_q),
        .wr_addr (ADDR_W'(col_s1_q)),
        .wr_data (t1)
    );

    always_comb begin
        win_d   = win_q;
        odval_d = 1'b0;
        ox_d    = ox_q;
        oy_d    = oy_q;
        if (vld_s1_q) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = t2;
            win_d[1][2] = t1;
            win_d[2][2] = p_s1_q;
            ox_d        = col_s1_q;
            oy_d        = row_s1_q;
`ifdef GW_ZERO_BORDER_EN
            odval_d     = 1'b1;
`else
            odval_d     = (col_s1_q >= CNT_W'(2)) && (row_s1_q >= CNT_W'(2));
`endif
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col_q    <= '0;
            row_q    <= '0;
            vld_s1_q <= 1'b0;
            p_s1_q   <= '0;
            col_s1_q <= '0;
            row_s1_q <= '0;
            win_q    <= '0;
            odval_q  <= 1'b0;
            ox_q     <= '0;
            oy_q     <= '0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            vld_s1_q <= vld_s1_d;
            p_s1_q   <= p_s1_d;
            col_s1_q <= col_s1_d;
            row_s1_q <= row_s1_d;
            win_q    <= win_d;
            odval_q  <= odval_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
        end
    end

`ifdef GW_ZERO_BORDER_EN
    win_t owin_q, owin_d;

    // Zero taps above row 0 or left of col 0; also hides unwritten RAM
    always_comb begin
        owin_d = owin_q;
        if (vld_s1_q) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    owin_d[r][c] = ((row_s1_q >= CNT_W'(2 - r)) && (col_s1_q >= CNT_W'(2 - c)))
                                   ? win_d[r][c] : '0;
                end
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            owin_q <= '0;
        end else begin
            owin_q <= owin_d;
        end
    end

    assign oWin = owin_q;
`else
    assign oWin = win_q;
`endif

    assign oDVAL   = odval_q;
    assign oX_Cont = ox_q;
    assign oY_Cont = oy_q;

endmodule

// File: tb/tb_gray_window3x3.sv
// Directed bench for gray_window3x3 with IMG_W=8 and test pixel value row*16+col.
module tb_gray_window3x3;

    localparam int unsigned DW = 12;
    localparam int unsigned IW = 8;
    localparam int unsigned CW = 11;
    localparam int unsigned WW = 9 * DW;
    localparam int NPIX = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          dval;
    logic [CW-1:0] xin, yin;
    logic [WW-1:0] owin;
    logic          odval;
    logic [CW-1:0] ox, oy;

    always #5 clk = ~clk;

    gray_window3x3 #(.DATA_W(DW), .IMG_W(IW), .CNT_W(CW)) dut (
        .iCLK    (clk),
        .iRST    (rst_n),
        .iDATA   (data),
        .iDVAL   (dval),
        .iX_Cont (xin),
        .iY_Cont (yin),
        .oWin    (owin),
        .oDVAL   (odval),
        .oX_Cont (ox),
        .oY_Cont (oy)
    );

    typedef struct {
        logic [WW-1:0] w;
        int            x;
        int            y;
        int            cyc;
    } ev_t;

    int       cyc = 0;
    ev_t      evq[$];
    ev_t      ref_q[$];
    int       gap_err = 0;
    logic [2:0] hist = 3'b000;
    int       img [6][8];
    int       pres_arr [NPIX];
    int       n_chk = 0;
    int       n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // A window seen in cycle k belongs to the pixel presented in cycle k-2
    always @(negedge clk) begin
        hist = {hist[1:0], dval};
        if (odval === 1'b1) begin
            evq.push_back('{owin, int'(ox), int'(oy), cyc});
            if (!hist[2]) gap_err++;
        end
    end

    function automatic logic [WW-1:0] exp_win(input int c, input int r);
        logic [WW-1:0] e;
        e = '0;
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                if (r - 2 + rr >= 0 && c - 2 + cc >= 0)
                    e[(rr*3+cc)*DW +: DW] = DW'(img[r-2+rr][c-2+cc]);
            end
        end
        return e;
    endfunction

    task automatic set_ramp();
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = r * 16 + c;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input int x, input int y, output int pres);
        data = d;
        xin  = CW'(x);
        yin  = CW'(y);
        dval = 1'b1;
        pres = cyc;
        @(posedge clk);
        #1;
        dval = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic send_frame(input int max_gap, input int first);
        for (int i = first; i < NPIX; i++) begin
            send(DW'(img[i/8][i%8]), i % 8, i / 8, pres_arr[i]);
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_chk++; if (odval !== 1'b0) $display("FAIL reset_odval got %0b want 0", odval); else n_pass++;
        n_chk++; if (owin !== '0) $display("FAIL reset_owin got %h want 0", owin); else n_pass++;
        n_chk++; if (ox !== '0) $display("FAIL reset_ox got %0d want 0", ox); else n_pass++;
        n_chk++; if (oy !== '0) $display("FAIL reset_oy got %0d want 0", oy); else n_pass++;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

`ifdef GW_ZERO_BORDER_EN
    task automatic test_zero_border();
        int base;
        int n;
        logic [WW-1:0] e;
        do_reset();
        set_ramp();
        img[0][0] = 5;
        base = evq.size();
        send(12'd5, 0, 0, pres_arr[0]);
        idle(3);
        e = '0;
        e[8*DW +: DW] = 12'd5;
        n_chk++; if (evq.size() - base !== 1) $display("FAIL zb_first_count got %0d want 1", evq.size() - base); else n_pass++;
        if (evq.size() > base) begin
            n_chk++; if (evq[base].w !== e) $display("FAIL zb_first_win got %h want %h", evq[base].w, e); else n_pass++;
            n_chk++; if (evq[base].x !== 0 || evq[base].y !== 0) $display("FAIL zb_first_xy got %0d,%0d want 0,0", evq[base].x, evq[base].y); else n_pass++;
        end
        send_frame(0, 1);
        idle(4);
        n = evq.size() - base;
        n_chk++; if (n !== 48) $display("FAIL zb_frame_count got %0d want 48", n); else n_pass++;
        for (int i = base; i < evq.size(); i++) begin
            e = exp_win(evq[i].x, evq[i].y);
            n_chk++; if (evq[i].w !== e) $display("FAIL zb_win(%0d,%0d) got %h want %h", evq[i].x, evq[i].y, evq[i].w, e); else n_pass++;
        end
    endtask
`else
    task automatic test_ramp_window();
        int base;
        int k;
        logic [WW-1:0] e;
        do_reset();
        set_ramp();
        base = evq.size();
        send_frame(0, 0);
        idle(4);
        k = -1;
        for (int i = base; i < evq.size(); i++)
            if (evq[i].x == 4 && evq[i].y == 3) k = i;
        e = {12'h034, 12'h033, 12'h032, 12'h024, 12'h023, 12'h022, 12'h014, 12'h013, 12'h012};
        n_chk++; if (k < 0) $display("FAIL ramp_found got none want window at (4,3)"); else n_pass++;
        if (k >= 0) begin
            n_chk++; if (evq[k].cyc !== pres_arr[28] + 2) $display("FAIL ramp_latency got cycle %0d want %0d", evq[k].cyc, pres_arr[28] + 2); else n_pass++;
            n_chk++; if (evq[k].w !== e) $display("FAIL ramp_win got %h want %h", evq[k].w, e); else n_pass++;
        end
    endtask

    task automatic test_frame_count();
        int base;
        int n;
        logic ok;
        do_reset();
        set_ramp();
        base = evq.size();
        send_frame(0, 0);
        idle(4);
        n = evq.size() - base;
        n_chk++; if (n !== 24) $display("FAIL frame_count got %0d want 24", n); else n_pass++;
        ref_q.delete();
        for (int i = base; i < evq.size(); i++) begin
            ref_q.push_back(evq[i]);
            ok = (evq[i].x >= 2) && (evq[i].y >= 2) && (evq[i].w === exp_win(evq[i].x, evq[i].y));
            n_chk++; if (!ok) $display("FAIL frame_win(%0d,%0d) got %h want %h", evq[i].x, evq[i].y, evq[i].w, exp_win(evq[i].x, evq[i].y)); else n_pass++;
        end
    endtask

    task automatic test_gap_stall();
        int base;
        int g0;
        int n;
        logic [WW-1:0] snap;
        do_reset();
        set_ramp();
        g0 = gap_err;
        base = evq.size();
        send_frame(3, 0);
        idle(4);
        n = evq.size() - base;
        n_chk++; if (n !== ref_q.size()) $display("FAIL gap_count got %0d want %0d", n, ref_q.size()); else n_pass++;
        for (int i = 0; i < n && i < ref_q.size(); i++) begin
            n_chk++;
            if (evq[base+i].w !== ref_q[i].w || evq[base+i].x !== ref_q[i].x || evq[base+i].y !== ref_q[i].y)
                $display("FAIL gap_seq[%0d] got (%0d,%0d) %h want (%0d,%0d) %h", i, evq[base+i].x, evq[base+i].y,
                         evq[base+i].w, ref_q[i].x, ref_q[i].y, ref_q[i].w);
            else n_pass++;
        end
        n_chk++; if (gap_err !== g0) $display("FAIL gap_odval got %0d pulses in gaps want 0", gap_err - g0); else n_pass++;
        snap = owin;
        idle(3);
        n_chk++; if (owin !== snap) $display("FAIL stall_hold got %h want %h", owin, snap); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int base;
        int dummy;
        do_reset();
        set_ramp();
        for (int i = 0; i < 13; i++) send(12'hAAA, i % 8, i / 8, dummy);
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (odval !== 1'b0) $display("FAIL rstmid_odval got %0b want 0", odval); else n_pass++;
        n_chk++; if (owin !== '0) $display("FAIL rstmid_owin got %h want 0", owin); else n_pass++;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        base = evq.size();
        for (int i = 0; i < 24; i++) send(DW'(img[i/8][i%8]), 5, 5, pres_arr[i]);
        idle(4);
        n_chk++; if (evq.size() - base !== 6) $display("FAIL rstmid_count got %0d want 6", evq.size() - base); else n_pass++;
        if (evq.size() > base) begin
            n_chk++; if (evq[base].x !== 2 || evq[base].y !== 2) $display("FAIL rstmid_first_xy got %0d,%0d want 2,2", evq[base].x, evq[base].y); else n_pass++;
            n_chk++; if (evq[base].w !== exp_win(2, 2)) $display("FAIL rstmid_first_win got %h want %h", evq[base].w, exp_win(2, 2)); else n_pass++;
            n_chk++; if (evq[base].cyc !== pres_arr[18] + 2) $display("FAIL rstmid_latency got %0d want %0d", evq[base].cyc, pres_arr[18] + 2); else n_pass++;
        end
    endtask

    task automatic test_resync();
        int base;
        int dummy;
        do_reset();
        set_ramp();
        base = evq.size();
        for (int i = 0; i < 13; i++) send(12'hBBB, i % 8, i / 8, dummy);
        for (int j = 0; j < 24; j++) send(DW'(img[j/8][j%8]), j % 8, j / 8, pres_arr[j]);
        idle(4);
        n_chk++; if (evq.size() - base !== 6) $display("FAIL resync_count got %0d want 6", evq.size() - base); else n_pass++;
        if (evq.size() > base) begin
            n_chk++; if (evq[base].x !== 2 || evq[base].y !== 2) $display("FAIL resync_first_xy got %0d,%0d want 2,2", evq[base].x, evq[base].y); else n_pass++;
            n_chk++; if (evq[base].cyc !== pres_arr[18] + 2) $display("FAIL resync_latency got %0d want %0d", evq[base].cyc, pres_arr[18] + 2); else n_pass++;
            n_chk++; if (evq[base].w !== exp_win(2, 2)) $display("FAIL resync_first_win got %h want %h", evq[base].w, exp_win(2, 2)); else n_pass++;
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        dval  = 1'b0;
        data  = '0;
        xin   = '0;
        yin   = '0;
        #1;
        test_reset();
`ifdef GW_ZERO_BORDER_EN
        test_zero_border();
`else
        test_ramp_window();
        test_frame_count();
        test_gap_stall();
        test_reset_mid();
        test_resync();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
